// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU datapath types.
//   word_t        32-bit machine word
//   regbits_t     5-bit register index
//   IFID_BUBBLE   instruction word used for an empty IF/ID latch (sll $0 = nop)
//   ifid_entry_t  one IF/ID slot: valid bit, instruction, PC+4
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam word_t IFID_BUBBLE = 32'h0000_0000;

    typedef struct packed {
        logic  v;
        word_t instr;
        word_t npc;
    } ifid_entry_t;

    // Empty slot carrying the given bubble word and a zero npc.
    function automatic ifid_entry_t ifid_empty(input word_t bubble);
        ifid_entry_t e;
        e.v     = 1'b0;
        e.instr = bubble;
        e.npc   = '0;
        return e;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    clock, rising edge
//   rst    asynchronous active-high clear
//   inc    count one this cycle
//   count  current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ifid_skid_latch.sv
// ifid_skid_latch
// IF/ID pipeline register with a one-entry skid buffer. A fetch that
// arrives while decode is stalled is parked in the skid so it is neither
// lost nor refetched; a second fetch during the same stall is refused
// through pc_en. Flushes clear both the latch and the skid.
//   CLK, RST             clock / asynchronous active-high reset
//   ihit                 imemload/npc_in valid this cycle
//   imemload, npc_in     fetched instruction and its PC+4
//   stall_ifid           hold the latch
//   flush_ifid           discard latch + skid (jump / hazard)
//   flush_branch_ifid    discard latch + skid (branch mispredict)
//   pc_en                fetch accepted, PC may advance
//   instr_ifid, npc_ifid latched instruction and npc to decode
//   valid_ifid           latch holds a real instruction
//   rs_ifid, rt_ifid     register fields of instr_ifid for the hazard unit
//   stall_cnt            saturating count of stalled cycles with a valid latch
//   flush_cnt            saturating count of flush cycles
module ifid_skid_latch
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 16,
    parameter logic [DATA_W-1:0] BUBBLE_INSTR = IFID_BUBBLE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [DATA_W-1:0] imemload,
    input  logic [DATA_W-1:0] npc_in,
    input  logic              stall_ifid,
    input  logic              flush_ifid,
    input  logic              flush_branch_ifid,
    output logic              pc_en,
    output logic [DATA_W-1:0] instr_ifid,
    output logic [DATA_W-1:0] npc_ifid,
    output logic              valid_ifid,
    output logic [4:0]        rs_ifid,
    output logic [4:0]        rt_ifid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ifid_entry_t latch;
    ifid_entry_t skid;
    ifid_entry_t fetched;
    logic        flush_any;

    assign flush_any = flush_ifid | flush_branch_ifid;

    assign fetched.v     = 1'b1;
    assign fetched.instr = imemload;
    assign fetched.npc   = npc_in;

    // A full skid during a stall has nowhere to put a new word, so the PC
    // must not advance and the same address is fetched again later.
    assign pc_en = ihit & ~(skid.v & stall_ifid) & ~flush_any;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            latch <= ifid_empty(BUBBLE_INSTR);
            skid  <= ifid_empty('0);
        end else if (flush_any) begin
            latch <= ifid_empty(BUBBLE_INSTR);
            skid  <= ifid_empty('0);
        end else if (stall_ifid) begin
            if (ihit && !skid.v) begin
                skid <= fetched;
            end
        end else if (skid.v) begin
            // The skid entry is older than any same-cycle fetch, so it goes
            // to decode first and the new word takes its place.
            latch <= skid;
            if (ihit) begin
                skid <= fetched;
            end else begin
                skid.v <= 1'b0;
            end
        end else if (ihit) begin
            latch <= fetched;
        end else begin
            latch <= ifid_empty(BUBBLE_INSTR);
        end
    end

    assign instr_ifid = latch.instr;
    assign npc_ifid   = latch.npc;
    assign valid_ifid = latch.v;
    assign rs_ifid    = latch.instr[25:21];
    assign rt_ifid    = latch.instr[20:16];

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_ifid & latch.v & ~flush_any),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (flush_any),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_ifid_skid_latch.sv
module tb_ifid_skid_latch;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic [31:0] npc_in;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        flush_branch_ifid;
    logic        pc_en;
    logic [31:0] instr_ifid;
    logic [31:0] npc_ifid;
    logic        valid_ifid;
    logic [4:0]  rs_ifid;
    logic [4:0]  rt_ifid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    ifid_skid_latch #(
        .DATA_W       (32),
        .CNT_W        (16),
        .BUBBLE_INSTR (32'h0)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .ihit              (ihit),
        .imemload          (imemload),
        .npc_in            (npc_in),
        .stall_ifid        (stall_ifid),
        .flush_ifid        (flush_ifid),
        .flush_branch_ifid (flush_branch_ifid),
        .pc_en             (pc_en),
        .instr_ifid        (instr_ifid),
        .npc_ifid          (npc_ifid),
        .valid_ifid        (valid_ifid),
        .rs_ifid           (rs_ifid),
        .rt_ifid           (rt_ifid),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words accepted by the block but not yet handed to decode.
    logic [63:0] pend_q[$];
    logic        exp_v;
    logic [31:0] exp_instr;
    logic [31:0] exp_npc;
    int          exp_stall;
    int          exp_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_v     = 1'b0;
        exp_instr = 32'h0;
        exp_npc   = 32'h0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":valid"}, 32'(valid_ifid), 32'(exp_v));
        chk({tag, ":instr"}, instr_ifid, exp_instr);
        chk({tag, ":npc"}, npc_ifid, exp_npc);
        chk({tag, ":rs"}, 32'(rs_ifid), 32'(exp_instr[25:21]));
        chk({tag, ":rt"}, 32'(rt_ifid), 32'(exp_instr[20:16]));
        chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, ":flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    // One clock cycle: drive at the falling edge, check pc_en mid-cycle,
    // update the scoreboard, then check registered outputs after the edge.
    task automatic step(input string tag, input logic hi, input logic [31:0] ins,
                        input logic [31:0] np, input logic st, input logic fj,
                        input logic fb);
        logic        acc;
        logic        fl;
        logic [63:0] e;
        @(negedge CLK);
        ihit              = hi;
        imemload          = ins;
        npc_in            = np;
        stall_ifid        = st;
        flush_ifid        = fj;
        flush_branch_ifid = fb;
        #1;
        fl  = fj | fb;
        acc = hi & ~fl & ~(st & (pend_q.size() != 0));
        chk({tag, ":pc_en"}, 32'(pc_en), 32'(acc));
        if (fl) begin
            pend_q.delete();
            exp_v     = 1'b0;
            exp_instr = 32'h0;
            exp_npc   = 32'h0;
            if (exp_flush < 16'hFFFF) exp_flush++;
        end else begin
            if (st && exp_v && exp_stall < 16'hFFFF) exp_stall++;
            if (acc) pend_q.push_back({ins, np});
            if (!st) begin
                if (pend_q.size() != 0) begin
                    e         = pend_q.pop_front();
                    exp_v     = 1'b1;
                    exp_instr = e[63:32];
                    exp_npc   = e[31:0];
                end else begin
                    exp_v     = 1'b0;
                    exp_instr = 32'h0;
                    exp_npc   = 32'h0;
                end
            end
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        RST               = 1'b1;
        ihit              = 1'b0;
        imemload          = 32'h0;
        npc_in            = 32'h0;
        stall_ifid        = 1'b0;
        flush_ifid        = 1'b0;
        flush_branch_ifid = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset:pc_en", 32'(pc_en), 32'h0);

        // Unstalled fetch lands in one cycle.
        step("t1", 1'b1, 32'h8C22_0004, 32'h4, 1'b0, 1'b0, 1'b0);
        chk("t1:rs_lit", 32'(rs_ifid), 32'd1);
        chk("t1:rt_lit", 32'(rt_ifid), 32'd2);

        // Stall with a fetch fills the skid; second fetch refused.
        step("t2a", 1'b1, 32'h0085_1020, 32'h8, 1'b1, 1'b0, 1'b0);
        step("t2b", 1'b1, 32'hDEAD_BEEF, 32'hC, 1'b1, 1'b0, 1'b0);
        step("t2c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t2:instr_lit", instr_ifid, 32'h0085_1020);
        step("t2d", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Branch flush with a full skid and a full latch.
        step("t3a", 1'b1, 32'h2001_0005, 32'h10, 1'b0, 1'b0, 1'b0);
        step("t3b", 1'b1, 32'h2002_0006, 32'h14, 1'b1, 1'b0, 1'b0);
        step("t3c", 1'b1, 32'h2003_0007, 32'h18, 1'b0, 1'b0, 1'b1);
        chk("t3:flush_lit", 32'(flush_cnt), 32'd1);
        step("t3d", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3:valid_lit", 32'(valid_ifid), 32'd0);

        // Stall and flush together: flush wins, no stall count.
        step("t4a", 1'b1, 32'h0123_4567, 32'h20, 1'b0, 1'b0, 1'b0);
        step("t4b", 1'b1, 32'h0ABC_DEF0, 32'h24, 1'b1, 1'b1, 1'b0);

        // Skid drain with a simultaneous new fetch keeps fetch order.
        step("ord1", 1'b1, 32'h1111_1111, 32'h30, 1'b0, 1'b0, 1'b0);
        step("ord2", 1'b1, 32'h2222_2222, 32'h34, 1'b1, 1'b0, 1'b0);
        step("ord3", 1'b1, 32'h3333_3333, 32'h38, 1'b0, 1'b0, 1'b0);
        step("ord4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step("ord5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Mixed traffic.
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

        // Long stall with a valid latch: stall_cnt saturates.
        step("t5a", 1'b1, 32'h0042_0800, 32'h40, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        ihit              = 1'b0;
        stall_ifid        = 1'b1;
        flush_ifid        = 1'b0;
        flush_branch_ifid = 1'b0;
        repeat (70000) @(posedge CLK);
        exp_stall = (exp_stall + 70000 > 32'hFFFF) ? 32'hFFFF : exp_stall + 70000;
        #1;
        chk("t5:sat", 32'(stall_cnt), 32'hFFFF);
        step("t5b", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset with the skid full.
        step("t6a", 1'b1, 32'h0064_0001, 32'h50, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        ihit       = 1'b0;
        stall_ifid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs("t6:async");
        @(negedge CLK);
        RST = 1'b0;
        step("t6b", 1'b1, 32'h03E0_0008, 32'h60, 1'b0, 1'b0, 1'b0);
        chk("t6:instr_lit", instr_ifid, 32'h03E0_0008);
        step("t6c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
